// File: rtl/async_counter_reader_pkg.sv
// Shared definitions for the ripple-counter read-out controller:
// FSM state encoding, default timing and the down-counter load helper.
package async_counter_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COUNT   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    localparam int DEFAULT_SETTLE = 4;
    localparam int DEFAULT_CLEAR  = 2;
    localparam int TIMER_W        = 8;

    // A phase lasting N cycles loads N-1 and leaves when the timer reads zero.
    function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/async_counter_reader_beat_sync.sv
// Multi-stage synchroniser for the asynchronous beat input followed by a
// rising-edge detector producing a one-cycle pulse in the clk domain.
module async_counter_reader_beat_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clrN,
    input  logic beat_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], beat_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/async_counter_reader.sv
// Read-out controller for an oscillator-clocked ripple counter: gates enable
// and clear, waits out ripple settling, captures the count and offers it on a
// one-entry valid/ready holding register.
module async_counter_reader
    import async_counter_reader_pkg::*;
#(
    parameter int width        = 16,
    parameter int syncStages   = 2,
    parameter int settleCycles = DEFAULT_SETTLE,
    parameter int clearCycles  = DEFAULT_CLEAR
) (
    input  logic             clk,
    input  logic             clrN,
    input  logic             en,
    input  logic             beat,
    input  logic [width-1:0] cnt,
    output logic             cntEn,
    output logic             cntClr,
    output logic [width-1:0] sampleCnt,
    output logic             sampleBit,
    output logic             sampleValid,
    input  logic             sampleReady,
    output logic             overflow
);

    // Handshake: a sample transfers on any clk edge where sampleValid && sampleReady;
    // sampleCnt holds steady while sampleValid is high and sampleReady is low.

    localparam logic [TIMER_W-1:0] SETTLE_LOAD = timer_load(settleCycles);
    localparam logic [TIMER_W-1:0] CLEAR_LOAD  = timer_load(clearCycles);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               cnt_en_q, cnt_en_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic [width-1:0]   sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               beat_rise;
    logic               capture;
    logic               load;

    async_counter_reader_beat_sync #(
        .STAGES(syncStages)
    ) u_beat_sync (
        .clk   (clk),
        .clrN  (clrN),
        .beat_i(beat),
        .rise_o(beat_rise)
    );

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b1;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_CLEAR;
                    timer_d = CLEAR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (timer_q == '0) state_d = ST_COUNT;
                else               timer_d = timer_q - TIMER_ONE;
            end
            ST_COUNT: begin
                // A closing beat takes priority over en dropping.
                if (beat_rise) begin
                    state_d = ST_SETTLE;
                    timer_d = SETTLE_LOAD;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == '0) state_d = ST_CAPTURE;
                else               timer_d = timer_q - TIMER_ONE;
            end
            ST_CAPTURE: begin
                if (en) begin
                    state_d = ST_CLEAR;
                    timer_d = CLEAR_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Counter controls are registered from the next state so they track it exactly.
        cnt_en_d  = (state_d == ST_COUNT);
        cnt_clr_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
    end

    always_comb begin
        capture    = (state_q == ST_CAPTURE);
        load       = capture && (!valid_q || sampleReady);
        sample_d   = sample_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (load) begin
            sample_d = cnt;
            valid_d  = 1'b1;
        end else if (valid_q && sampleReady) begin
            valid_d = 1'b0;
        end
        if (capture && !load) overflow_d = 1'b1;
    end

    assign cntEn       = cnt_en_q;
    assign cntClr      = cnt_clr_q;
    assign sampleCnt   = sample_q;
    assign sampleBit   = sample_q[0];
    assign sampleValid = valid_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_async_counter_reader.sv
// Directed bench for async_counter_reader: a behavioural ripple-counter model
// driven by an oscillator tick, a handshake log and hand-computed expectations.
module tb_async_counter_reader;

    logic        clk = 1'b0;
    logic        clrN;
    logic        en;
    logic        beat;
    logic [15:0] ctr;
    logic        cntEn;
    logic        cntClr;
    logic [15:0] sampleCnt;
    logic        sampleBit;
    logic        sampleValid;
    logic        sampleReady;
    logic        overflow;
    logic        osc_tick;

    int          vectors     = 0;
    int          miscompares = 0;
    int          en_clr_viol = 0;
    int          h0;
    logic [15:0] hs_q[$];

    async_counter_reader #(
        .width(16), .syncStages(2), .settleCycles(4), .clearCycles(2)
    ) dut (
        .clk        (clk),
        .clrN       (clrN),
        .en         (en),
        .beat       (beat),
        .cnt        (ctr),
        .cntEn      (cntEn),
        .cntClr     (cntClr),
        .sampleCnt  (sampleCnt),
        .sampleBit  (sampleBit),
        .sampleValid(sampleValid),
        .sampleReady(sampleReady),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Ripple counter model: cleared by cntClr, advances on an oscillator tick while enabled.
    always @(posedge clk) begin
        if (cntClr)               ctr <= 16'h0;
        else if (cntEn && osc_tick) ctr <= ctr + 16'h1;
    end

    always @(posedge clk) begin
        if (clrN && sampleValid && sampleReady) hs_q.push_back(sampleCnt);
    end

    always @(negedge clk) begin
        if (cntEn && cntClr) en_clr_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for the counter to run, counts to target, then raises beat on that negedge.
    task automatic open_window(input string tag, input logic [15:0] target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cntEn) begin ok = 1'b1; break; end
        end
        if (!ok) check({tag, "_wait_cnten"}, 32'(cntEn), 32'h1);
        osc_tick = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 32'(target) + 20; i++) begin
            if (ctr == target) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check({tag, "_wait_count"}, 32'(ctr), 32'(target));
        osc_tick = 1'b0;
        beat     = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clrN = 1'b0; en = 1'b0; beat = 1'b0; osc_tick = 1'b0; sampleReady = 1'b0;
        repeat (2) @(negedge clk);
        clrN = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clrN = 1'b0; en = 1'b1; beat = 1'b0; osc_tick = 1'b0; sampleReady = 1'b1;
        #1;
        // Reset holds while en is high and beat toggles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            beat = ~beat;
            check("rst_cnten",    32'(cntEn),       32'h0);
            check("rst_cntclr",   32'(cntClr),      32'h1);
            check("rst_valid",    32'(sampleValid), 32'h0);
            check("rst_overflow", 32'(overflow),    32'h0);
        end
        check("rst_samplecnt", 32'(sampleCnt), 32'h0);
        en = 1'b0; beat = 1'b0;
        @(negedge clk);
        clrN = 1'b1;
        @(negedge clk);

        // Basic window with consumer always ready.
        en = 1'b1;
        @(negedge clk);
        check("clr_c1_cntclr", 32'(cntClr), 32'h1);
        check("clr_c1_cnten",  32'(cntEn),  32'h0);
        @(negedge clk);
        check("clr_c2_cntclr", 32'(cntClr), 32'h1);
        @(negedge clk);
        check("count_cnten",  32'(cntEn),  32'h1);
        check("count_cntclr", 32'(cntClr), 32'h0);
        open_window("basic", 16'h01A3);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 2) check("basic_cnten_n2", 32'(cntEn), 32'h1);
            if (n == 3) begin check("basic_cnten_n3", 32'(cntEn), 32'h0); beat = 1'b0; end
            if (n == 7) check("basic_valid_n7", 32'(sampleValid), 32'h0);
            if (n == 8) begin
                check("basic_valid_n8", 32'(sampleValid), 32'h1);
                check("basic_cnt",      32'(sampleCnt),   32'h01A3);
                check("basic_bit",      32'(sampleBit),   32'h1);
            end
            if (n == 9) check("basic_valid_n9", 32'(sampleValid), 32'h0);
        end
        check("basic_hs_last", 32'(hs_q[$]), 32'h01A3);

        // Backpressure: second capture finds the register full.
        sampleReady = 1'b0;
        open_window("bp1", 16'd5);
        repeat (3) @(negedge clk);
        beat = 1'b0;
        repeat (5) @(negedge clk);
        check("bp1_valid", 32'(sampleValid), 32'h1);
        check("bp1_cnt",   32'(sampleCnt),   32'd5);
        open_window("bp2", 16'd9);
        repeat (3) @(negedge clk);
        beat = 1'b0;
        repeat (5) @(negedge clk);
        check("bp2_overflow", 32'(overflow),    32'h1);
        check("bp2_cnt",      32'(sampleCnt),   32'd5);
        check("bp2_valid",    32'(sampleValid), 32'h1);
        h0 = hs_q.size();
        sampleReady = 1'b1;
        @(negedge clk);
        check("bp_drain_valid", 32'(sampleValid), 32'h0);
        check("bp_drain_hs",    32'(hs_q.size()), 32'(h0 + 1));
        check("bp_drain_value", 32'(hs_q[$]),     32'd5);

        // Same-cycle drain and load on the capture cycle.
        apply_reset();
        check("rst2_overflow", 32'(overflow), 32'h0);
        en = 1'b1;
        open_window("sc1", 16'd3);
        repeat (3) @(negedge clk);
        beat = 1'b0;
        repeat (5) @(negedge clk);
        check("sc1_valid", 32'(sampleValid), 32'h1);
        open_window("sc2", 16'd7);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 3) beat = 1'b0;
            if (n == 7) begin
                check("sc_pre_valid", 32'(sampleValid), 32'h1);
                check("sc_pre_cnt",   32'(sampleCnt),   32'd3);
                sampleReady = 1'b1;
            end
            if (n == 8) begin
                sampleReady = 1'b0;
                check("sc_valid",    32'(sampleValid), 32'h1);
                check("sc_cnt",      32'(sampleCnt),   32'd7);
                check("sc_overflow", 32'(overflow),    32'h0);
                check("sc_hs_last",  32'(hs_q[$]),     32'd3);
            end
        end

        // Beat edges during SETTLE and CLEAR are ignored.
        sampleReady = 1'b1;
        repeat (2) @(negedge clk);
        h0 = hs_q.size();
        open_window("ign", 16'd11);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 3) beat = 1'b0;
            if (n == 4) beat = 1'b1;
            if (n == 6) beat = 1'b0;
            if (n == 7) beat = 1'b1;
            if (n == 9) beat = 1'b0;
        end
        repeat (30) @(negedge clk);
        check("ign_hs_count", 32'(hs_q.size()), 32'(h0 + 1));
        check("ign_hs_value", 32'(hs_q[$]),     32'd11);
        check("ign_counting", 32'(cntEn),       32'h1);

        // en drop during SETTLE: sample still delivered, then IDLE.
        open_window("endrop", 16'd4);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 3) beat = 1'b0;
            if (n == 4) en = 1'b0;
            if (n == 8) begin
                check("endrop_valid", 32'(sampleValid), 32'h1);
                check("endrop_cnt",   32'(sampleCnt),   32'd4);
            end
            if (n == 9) check("endrop_valid_n9", 32'(sampleValid), 32'h0);
        end
        repeat (3) @(negedge clk);
        check("endrop_idle_cntclr", 32'(cntClr),   32'h1);
        check("endrop_idle_cnten",  32'(cntEn),    32'h0);
        check("endrop_hs_value",    32'(hs_q[$]),  32'd4);

        // Reset asserted during SETTLE: immediate reset values, no sample.
        en = 1'b1;
        open_window("rstmid", 16'd6);
        h0 = hs_q.size();
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 3) beat = 1'b0;
        end
        clrN = 1'b0;
        #1;
        check("rstmid_cnten",  32'(cntEn),       32'h0);
        check("rstmid_cntclr", 32'(cntClr),      32'h1);
        check("rstmid_valid",  32'(sampleValid), 32'h0);
        check("rstmid_cnt",    32'(sampleCnt),   32'h0);
        repeat (2) @(negedge clk);
        clrN = 1'b1; en = 1'b0;
        repeat (15) @(negedge clk);
        check("rstmid_no_hs",    32'(hs_q.size()), 32'(h0));
        check("rstmid_valid_after", 32'(sampleValid), 32'h0);

        check("en_clr_exclusive", 32'(en_clr_viol), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
